// File: rtl/lvdc_din_serializer.sv
// lvdc_din_serializer: shifts a parallel word MSB-first onto DIN/DATAV, paced by computer bit strobes.
`timescale 1ns/1ps
module lvdc_din_serializer #(
    parameter int WIDTH = 26,
    parameter int CNTW  = 8
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic [WIDTH-1:0] WORD,
    input  logic             WVALID,
    output logic             WREADY,
    input  logic             BITSTB,
    input  logic             WSTB,
    input  logic             ABORT,
    output logic             DIN,
    output logic             DATAV,
    output logic             DONE,
    output logic [CNTW-1:0]  WCNT
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, ARMED, SHIFT} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  sr_q, sr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              din_q, din_d, datav_q, datav_d, done_q, done_d;
    logic [CNTW-1:0]   wcnt_q, wcnt_d;

    // RSTN gates WREADY directly so it reads 0 throughout reset.
    assign WREADY = RSTN && !ABORT && (state_q == IDLE);
    assign DIN    = din_q;
    assign DATAV  = datav_q;
    assign DONE   = done_q;
    assign WCNT   = wcnt_q;

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        din_d   = din_q;
        datav_d = datav_q;
        done_d  = 1'b0;
        wcnt_d  = wcnt_q;
        if (ABORT && state_q != IDLE) begin
            state_d = IDLE;
            din_d   = 1'b0;
            datav_d = 1'b0;
        end else if (state_q == IDLE) begin
            if (WVALID && WREADY) begin
                sr_d    = WORD;
                state_d = ARMED;
            end
        end else if (state_q == ARMED) begin
            if (BITSTB && WSTB) begin
                state_d = SHIFT;
                din_d   = sr_q[WIDTH-1];
                datav_d = 1'b1;
                sr_d    = {sr_q[WIDTH-2:0], 1'b0};
                cnt_d   = LAST;
            end
        end else if (BITSTB) begin
            // The strobe after the last bit retires the word rather than shifting.
            if (cnt_q != '0) begin
                din_d = sr_q[WIDTH-1];
                sr_d  = {sr_q[WIDTH-2:0], 1'b0};
                cnt_d = cnt_q - CW'(1);
            end else begin
                state_d = IDLE;
                din_d   = 1'b0;
                datav_d = 1'b0;
                done_d  = 1'b1;
                wcnt_d  = wcnt_q + CNTW'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            din_q   <= 1'b0;
            datav_q <= 1'b0;
            done_q  <= 1'b0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            din_q   <= din_d;
            datav_q <= datav_d;
            done_q  <= done_d;
            wcnt_q  <= wcnt_d;
        end
    end
endmodule

// File: tb/tb_lvdc_din_serializer.sv
// tb_lvdc_din_serializer: directed stimulus with a queue scoreboard checking each completed word.
`timescale 1ns/1ps
module tb_lvdc_din_serializer;
    localparam int W = 26;
    localparam int CNTW = 2;

    logic            CLK = 1'b0;
    logic            RSTN = 1'b0;
    logic [W-1:0]    WORD = '0;
    logic            WVALID = 1'b0;
    logic            WREADY;
    logic            BITSTB = 1'b0;
    logic            WSTB = 1'b0;
    logic            ABORT = 1'b0;
    logic            DIN, DATAV, DONE;
    logic [CNTW-1:0] WCNT;

    typedef struct packed {
        logic [W-1:0]    word;
        logic [CNTW-1:0] cnt;
    } exp_t;

    exp_t            q[$];
    int              n_vec = 0;
    int              n_err = 0;
    logic [CNTW-1:0] exp_cnt = '0;
    logic [W-1:0]    acc = '0;
    int              nbits = 0;
    logic            bs_seen = 1'b0;

    lvdc_din_serializer #(.WIDTH(W), .CNTW(CNTW)) dut (
        .CLK(CLK), .RSTN(RSTN), .WORD(WORD), .WVALID(WVALID), .WREADY(WREADY),
        .BITSTB(BITSTB), .WSTB(WSTB), .ABORT(ABORT), .DIN(DIN), .DATAV(DATAV),
        .DONE(DONE), .WCNT(WCNT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Present a word for one cycle; only words expected to complete go on the scoreboard.
    task automatic send(input logic [W-1:0] w, input bit push);
        WORD = w;
        WVALID = 1'b1;
        #1 chk("wready_accept", {31'd0, WREADY}, 32'd1);
        @(negedge CLK);
        WVALID = 1'b0;
        if (push) begin
            exp_cnt = exp_cnt + 1'b1;
            q.push_back('{word: w, cnt: exp_cnt});
        end
    endtask

    task automatic strobe(input logic ws, input int gap);
        BITSTB = 1'b1;
        WSTB = ws;
        @(negedge CLK);
        BITSTB = 1'b0;
        WSTB = 1'b0;
        repeat (gap) @(negedge CLK);
    endtask

    task automatic full_word(input int wstb_at);
        strobe(1'b1, 1);
        for (int i = 0; i < W; i++) strobe(i == wstb_at, 1);
    endtask

    always @(posedge CLK) bs_seen <= BITSTB;

    // Monitor: rebuild the serial word from bits seen after each strobe edge, check on DONE.
    always @(negedge CLK) begin
        if (DONE) begin
            if (q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL done_unexpected: got DONE=1 expected no completion");
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("serial_word", {6'd0, acc}, {6'd0, e.word});
                chk("serial_bits", nbits, W);
                chk("wcnt_on_done", {30'd0, WCNT}, {30'd0, e.cnt});
            end
            acc = '0;
            nbits = 0;
        end else if (!DATAV) begin
            acc = '0;
            nbits = 0;
        end else if (bs_seen) begin
            acc = {acc[W-2:0], DIN};
            nbits++;
        end
    end

    initial begin
        logic [W-1:0] words [4];
        words[0] = 26'h0000001;
        words[1] = 26'h2AAAAAA;
        words[2] = 26'h1234567;
        words[3] = 26'h3000000;
        #3;
        chk("rst_din", {31'd0, DIN}, 32'd0);
        chk("rst_datav", {31'd0, DATAV}, 32'd0);
        chk("rst_done", {31'd0, DONE}, 32'd0);
        chk("rst_wcnt", {30'd0, WCNT}, 32'd0);
        chk("rst_wready", {31'd0, WREADY}, 32'd0);
        @(negedge CLK);
        RSTN = 1'b1;
        @(negedge CLK);

        // Sign-and-LSB word: DIN 1, 24x0, 1
        send(26'h2000001, 1'b1);
        full_word(-1);
        chk("wcnt_first", {30'd0, WCNT}, 32'd1);

        // Unpaired strobes while armed are ignored; WSTB mid-shift is ignored
        send(26'h1555AAA, 1'b1);
        for (int i = 0; i < 10; i++) strobe(1'b0, 1);
        WSTB = 1'b1;
        @(negedge CLK);
        WSTB = 1'b0;
        chk("armed_datav", {31'd0, DATAV}, 32'd0);
        full_word(7);

        // Abort on the 5th bit, coincident with a strobe
        send(26'h3FFFFFF, 1'b0);
        strobe(1'b1, 1);
        for (int i = 0; i < 4; i++) strobe(1'b0, 1);
        chk("abort_pre_datav", {31'd0, DATAV}, 32'd1);
        ABORT = 1'b1;
        BITSTB = 1'b1;
        @(negedge CLK);
        chk("abort_datav", {31'd0, DATAV}, 32'd0);
        chk("abort_din", {31'd0, DIN}, 32'd0);
        chk("abort_done", {31'd0, DONE}, 32'd0);
        chk("abort_wcnt", {30'd0, WCNT}, 32'd2);
        chk("abort_wready_held", {31'd0, WREADY}, 32'd0);
        ABORT = 1'b0;
        BITSTB = 1'b0;
        #1 chk("abort_wready", {31'd0, WREADY}, 32'd1);

        // Abort in IDLE blocks acceptance
        @(negedge CLK);
        ABORT = 1'b1;
        WVALID = 1'b1;
        WORD = 26'h1FFFFFF;
        #1 chk("idle_abort_wready", {31'd0, WREADY}, 32'd0);
        @(negedge CLK);
        ABORT = 1'b0;
        WVALID = 1'b0;
        #1 chk("idle_abort_not_taken", {31'd0, WREADY}, 32'd1);
        @(negedge CLK);
        strobe(1'b1, 1);
        chk("idle_abort_no_shift", {31'd0, DATAV}, 32'd0);

        // Asynchronous reset at bit 12
        send(26'h0ABCDEF, 1'b0);
        strobe(1'b1, 1);
        for (int i = 0; i < 11; i++) strobe(1'b0, 1);
        chk("prereset_datav", {31'd0, DATAV}, 32'd1);
        #2 RSTN = 1'b0;
        #1;
        chk("async_din", {31'd0, DIN}, 32'd0);
        chk("async_datav", {31'd0, DATAV}, 32'd0);
        chk("async_wready", {31'd0, WREADY}, 32'd0);
        chk("async_wcnt", {30'd0, WCNT}, 32'd0);
        @(negedge CLK);
        RSTN = 1'b1;
        exp_cnt = '0;
        #1 chk("postreset_wready", {31'd0, WREADY}, 32'd1);
        @(negedge CLK);
        strobe(1'b1, 1);
        chk("no_resume", {31'd0, DATAV}, 32'd0);

        // WVALID held high with junk WORD during SHIFT takes nothing
        send(26'h2468ACE, 1'b1);
        WVALID = 1'b1;
        WORD = 26'h3C3C3C3;
        strobe(1'b1, 1);
        for (int i = 0; i < W - 1; i++) strobe(1'b0, 1);
        WVALID = 1'b0;
        strobe(1'b0, 1);
        chk("held_wvalid_idle", {31'd0, WREADY}, 32'd1);

        // Back-to-back words, WCNT wraps at 2 bits
        for (int k = 0; k < 4; k++) begin
            send(words[k], 1'b1);
            strobe(1'b1, 1);
            for (int i = 0; i < W - 1; i++) strobe(1'b0, 1);
            strobe(1'b0, 0);
        end
        @(negedge CLK);
        chk("wcnt_wrap_final", {30'd0, WCNT}, 32'd1);
        chk("scoreboard_empty", q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
